// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch score pipeline: sequencer
// states, buffer slot indices, score width and an address-width helper.
package nw_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_DIAG = 3'd1,
    S_RD_LEFT = 3'd2,
    S_RD_UP   = 3'd3,
    S_WAIT    = 3'd4,
    S_DONE    = 3'd5
  } nw_state_t;

  // Output-manager buffer slots for the three neighbour scores.
  localparam logic [1:0] SLOT_DIAG = 2'd0;
  localparam logic [1:0] SLOT_LEFT = 2'd1;
  localparam logic [1:0] SLOT_UP   = 2'd2;

  localparam int SCORE_W = 9;

  // Smallest address width that covers the (n+1)x(n+1) score matrix.
  function automatic int min_addr_w(input int n);
    int cells;
    cells      = (n + 1) * (n + 1);
    min_addr_w = 63;
    for (int k = 62; k >= 0; k--)
      if ((64'd1 << k) >= 64'(cells)) min_addr_w = k;
  endfunction

endpackage

// File: rtl/cell_index_counter.sv
// Row-major cell walker for (1,1)..(N,N). Keeps i, j and the linear row base
// i*(N+1) incrementally so no multiplier is needed. Exposes the next-cycle
// row base and column so the sequencer can register addresses for the cell
// it is about to enter.
module cell_index_counter
  import nw_pkg::*;
#(
  parameter int N      = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic              last_cell,
  output logic [ADDR_W-1:0] cell_addr,
  output logic [ADDR_W-1:0] nxt_row_base,
  output logic [ADDR_W-1:0] nxt_j
);

  localparam logic [ADDR_W-1:0] NP1  = ADDR_W'(N + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] i_q, j_q, rb_q;
  logic [ADDR_W-1:0] nxt_i;

  // Next index values: clear starts at (1,1), advance steps row-major.
  always_comb begin
    nxt_i        = i_q;
    nxt_j        = j_q;
    nxt_row_base = rb_q;
    if (clear) begin
      nxt_i        = ONE;
      nxt_j        = ONE;
      nxt_row_base = NP1;
    end else if (advance) begin
      if (j_q == LAST) begin
        nxt_j        = ONE;
        nxt_i        = i_q + ONE;
        nxt_row_base = rb_q + NP1;
      end else begin
        nxt_j = j_q + ONE;
      end
    end
  end

  // Index registers; cell_addr is registered from the next values so it is
  // already correct in the first read cycle of a cell.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q       <= '0;
      j_q       <= '0;
      rb_q      <= '0;
      cell_addr <= '0;
    end else begin
      i_q       <= nxt_i;
      j_q       <= nxt_j;
      rb_q      <= nxt_row_base;
      cell_addr <= nxt_row_base + nxt_j;
    end
  end

  assign last_cell = (i_q == LAST) && (j_q == LAST);

endmodule

// File: rtl/score_read_sequencer.sv
// Issues diag/left/up score-RAM reads for every matrix cell in row-major
// order, waiting for the compute stage's cell_done between cells. All
// outputs are registered; en_read/count trail ram_re by the RAM read latency.
module score_read_sequencer
  import nw_pkg::*;
#(
  parameter int N      = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cell_done,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              en_read,
  output logic [1:0]        count,
  output logic [ADDR_W-1:0] cell_addr,
  output logic              busy,
  output logic              done
);

  if (ADDR_W < min_addr_w(N)) begin : g_addr_w_chk
    $error("score_read_sequencer: ADDR_W too small for (N+1)^2 cells");
  end

  localparam logic [ADDR_W-1:0] NP1    = ADDR_W'(N + 1);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
  localparam int                RD_LAT = 1;

  nw_state_t         state, nxt_state;
  logic              clear, advance, last_cell;
  logic [ADDR_W-1:0] nxt_rb, nxt_j, up_base;
  logic              re_d, busy_d, done_d;
  logic [ADDR_W-1:0] addr_d;
  logic [1:0]        slot_d;

  // Read-valid and slot delay line: stage 0 drives the RAM, last stage
  // lines up with returned data.
  logic [RD_LAT:0]      vld_pipe;
  logic [RD_LAT:0][1:0] slot_pipe;

  cell_index_counter #(.N(N), .ADDR_W(ADDR_W)) u_idx (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .advance      (advance),
    .last_cell    (last_cell),
    .cell_addr    (cell_addr),
    .nxt_row_base (nxt_rb),
    .nxt_j        (nxt_j)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt_state;
  end

  // Next state plus index-counter control on the transitions that move cells.
  always_comb begin
    nxt_state = state;
    clear     = 1'b0;
    advance   = 1'b0;
    case (state)
      S_IDLE:    if (start) begin
                   clear     = 1'b1;
                   nxt_state = S_RD_DIAG;
                 end
      S_RD_DIAG: nxt_state = S_RD_LEFT;
      S_RD_LEFT: nxt_state = S_RD_UP;
      S_RD_UP:   nxt_state = S_WAIT;
      S_WAIT:    if (cell_done) begin
                   if (last_cell) nxt_state = S_DONE;
                   else begin
                     advance   = 1'b1;
                     nxt_state = S_RD_DIAG;
                   end
                 end
      S_DONE:    nxt_state = S_IDLE;
      default:   nxt_state = S_IDLE;
    endcase
  end

  // Output decode from the state being entered, so the registered outputs
  // are valid in that state's cycle.
  always_comb begin
    up_base = nxt_rb - NP1;
    re_d    = 1'b0;
    addr_d  = '0;
    slot_d  = SLOT_DIAG;
    case (nxt_state)
      S_RD_DIAG: begin
        re_d   = 1'b1;
        addr_d = up_base + nxt_j - ONE;
        slot_d = SLOT_DIAG;
      end
      S_RD_LEFT: begin
        re_d   = 1'b1;
        addr_d = nxt_rb + nxt_j - ONE;
        slot_d = SLOT_LEFT;
      end
      S_RD_UP: begin
        re_d   = 1'b1;
        addr_d = up_base + nxt_j;
        slot_d = SLOT_UP;
      end
      default: ;
    endcase
    busy_d = (nxt_state != S_IDLE);
    done_d = (nxt_state == S_DONE);
  end

  // Output registers and the read-latency delay line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vld_pipe  <= '0;
      slot_pipe <= '0;
    end else begin
      ram_addr  <= addr_d;
      busy      <= busy_d;
      done      <= done_d;
      vld_pipe  <= {vld_pipe[RD_LAT-1:0], re_d};
      slot_pipe <= {slot_pipe[RD_LAT-1:0], slot_d};
    end
  end

  assign ram_re  = vld_pipe[0];
  assign en_read = vld_pipe[RD_LAT];
  assign count   = slot_pipe[RD_LAT];

endmodule

// File: doc/score_read_sequencer.md
# score_read_sequencer

Issues the three score-RAM reads (diag, left, up) that each Needleman–Wunsch matrix cell needs, walking cells (1,1)..(N,N) in row-major order. It drives the score RAM read port and the `en_read`/`count` pair consumed by the output manager, which assembles diag/left/up for the cell-compute stage. The block waits for the compute stage's `cell_done` before moving to the next cell, so the written score is visible before any later cell reads it.

## Interface
- `N`, default 16: sequence length; the matrix is (N+1)×(N+1).
- `ADDR_W`, default 9: score RAM address width; must satisfy 2^ADDR_W ≥ (N+1)².
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `start` input 1: begin a full matrix pass; sampled only in IDLE.
- `cell_done` input 1: single-cycle pulse from compute stage when the current cell's score is written; sampled only in WAIT.
- `ram_re` output 1: score RAM read enable.
- `ram_addr` output ADDR_W: score RAM read address; the RAM has 1-cycle read latency.
- `en_read` output 1: RAM data valid for the output manager this cycle.
- `count` output 2: buffer slot of the current RAM data: 0 = diag, 1 = left, 2 = up.
- `cell_addr` output ADDR_W: linear address of the current cell, i*(N+1)+j, used as the write address.
- `busy` output 1: high from leaving IDLE until returning to IDLE.
- `done` output 1: one-cycle pulse after the last cell completes.

## Operation
- States: IDLE, RD_DIAG, RD_LEFT, RD_UP, WAIT, DONE.
- IDLE, `start`=1: set i=1, j=1, row_base=N+1, then go to RD_DIAG.
- RD_DIAG: `ram_addr` = row_base−(N+1)+j−1, `ram_re`=1, then RD_LEFT.
- RD_LEFT: `ram_addr` = row_base+j−1, `ram_re`=1, then RD_UP.
- RD_UP: `ram_addr` = row_base−(N+1)+j, `ram_re`=1, then WAIT.
- WAIT, `cell_done`=1:
  - If i=N and j=N, go to DONE.
  - Else if j=N, set j=1, i+=1, row_base+=N+1, and go to RD_DIAG.
  - Else set j+=1 and go to RD_DIAG.
- DONE: `done`=1 for one cycle, then IDLE.
- Addressing uses the incremental row_base register; there is no multiplier. All address arithmetic is unsigned ADDR_W-bit. Elaboration fails if (N+1)² > 2^ADDR_W.
- `en_read`/`count` are `ram_re` and the slot index delayed by one register, so they align with returned RAM data.
- `cell_addr` = row_base+j, held stable from RD_DIAG through WAIT.
- `start` is ignored while busy. `cell_done` is ignored outside WAIT.
- Reset, including mid-pass, returns to IDLE and abandons the pass. Any in-flight `en_read` is dropped.

## Timing
- Reset values: `ram_re`=0, `ram_addr`=0, `en_read`=0, `count`=0, `cell_addr`=0, `busy`=0, `done`=0.
- All outputs are registered.
- `start` sampled at edge T0:
  - T1: `ram_re`=1, diag address.
  - T2: `ram_re`=1, left address; `en_read`=1, `count`=0.
  - T3: `ram_re`=1, up address; `en_read`=1, `count`=1.
  - T4: `ram_re`=0; `en_read`=1, `count`=2.
- The output manager presents diag/left/up at T6.
- `cell_done` sampled at edge Tc starts the next cell's diag read at Tc+1. A `cell_done` arriving at T4 or later is legal.
- Minimum cell period is 4 cycles: 3 reads plus 1 WAIT cycle with immediate `cell_done`.
- `done` is asserted the cycle after the final `cell_done`. `busy` drops the cycle after `done`.
- `en_read` never overlaps between cells: consecutive cells' `count` sequences are 0,1,2 with no gaps inside a sequence.

## Structure
- Shared package `nw_pkg`:
  - The state encoding enum.
  - Slot constants SLOT_DIAG=0, SLOT_LEFT=1, SLOT_UP=2.
  - Score width 9.
  - A function returning the minimum ADDR_W for a given N.
- Natural sub-module `cell_index_counter`: holds i, j and row_base, with `clear`/`advance` inputs and `last_cell` and `cell_addr` outputs. The FSM and the read-delay register stay in the top.

## Test plan
- Reset value check: N=2, reset asserted mid-RD_LEFT → all outputs 0 in the same cycle; no `en_read` afterwards; IDLE on release.
- First cell, N=2, `start` pulse:
  - `ram_addr` 0,3,1 on T1–T3.
  - `en_read`/`count` (1,0),(1,1),(1,2) on T2–T4.
  - `cell_addr`=4.
- Row advance, N=2: `cell_done` on cell (1,2) → next reads 3,6,4; `cell_addr`=7.
- Full pass, N=2, `cell_done` 2 cycles after each WAIT entry:
  - Cell addresses 4,5,7,8.
  - Last cell reads 4,7,5.
  - `done` pulses exactly once, then `busy`=0.
- Ignored inputs:
  - `cell_done` pulsed during RD_LEFT → no effect; FSM still waits in WAIT for a fresh pulse.
  - `start` during a pass → no restart.
- Back-to-back: `cell_done` held high every cycle with N=3 → new cell every 4 cycles; `done` after 9 cells / 36+ cycles.
